// File: rtl/ysyx_25020047_ifu_pkg.sv
// Shared IFU definitions: FSM states, fault causes and the bubble instruction.
// Also imported by the IDU/WBU for fault decode.
package ysyx_25020047_ifu_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_NEXT
    } ifu_state_e;

    localparam logic CAUSE_MISALIGN = 1'b0;
    localparam logic CAUSE_ACCESS   = 1'b1;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_25020047_ifu_mc.sv
// Multi-cycle instruction fetch unit: one imem request per instruction,
// valid/ready hand-off to the IDU, next PC taken from the WBU.
module ysyx_25020047_ifu_mc
    import ysyx_25020047_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = ysyx_25020047_ifu_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault,
    output logic        out_cause,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_dnpc,
    output logic [31:0] fetch_cnt
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be word aligned");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    ifu_state_e      state;
    logic [31:0]     pc;
    logic [TW-1:0]   tcnt;
    logic            out_fire;
    logic            wb_fire;

    assign imem_req_valid = (state == S_REQ);
    assign imem_addr      = pc;
    assign out_valid      = (state == S_HOLD);
    assign out_pc         = pc;
    assign wb_ready       = (state == S_NEXT) | ((state == S_HOLD) & out_ready);
    assign out_fire       = out_valid & out_ready;
    assign wb_fire        = wb_valid & wb_ready;

    // Fetch FSM; a taken dnpc overrides the per-state transition.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            tcnt      <= '0;
            out_inst  <= NOP_INST;
            out_fault <= 1'b0;
            out_cause <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            if (out_fire) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (wb_fire) begin
                pc <= wb_dnpc;
                if (is_misaligned(wb_dnpc)) begin
                    state     <= S_HOLD;
                    out_inst  <= NOP_INST;
                    out_fault <= 1'b1;
                    out_cause <= CAUSE_MISALIGN;
                end else begin
                    state <= S_REQ;
                end
            end else begin
                unique case (state)
                    S_REQ: begin
                        if (imem_req_ready) begin
                            state <= S_WAIT;
                            tcnt  <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rsp_valid) begin
                            out_inst  <= imem_rsp_err ? NOP_INST
                                                      : imem_rsp_data;
                            out_fault <= imem_rsp_err;
                            out_cause <= CAUSE_ACCESS;
                            state     <= S_HOLD;
                        end else if (tcnt == TLAST) begin
                            out_inst  <= NOP_INST;
                            out_fault <= 1'b1;
                            out_cause <= CAUSE_ACCESS;
                            state     <= S_HOLD;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (out_fire) begin
                            state <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        state <= S_NEXT;
                    end
                endcase
            end
        end
    end

    // Responses are only legal while a fetch is outstanding.
    a_rsp_in_wait: assert property (
        @(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (state == S_WAIT)
    );

    // A pending request keeps its address until accepted.
    a_req_stable: assert property (
        @(posedge clk) disable iff (!rst)
        (imem_req_valid && !imem_req_ready) |=>
            (imem_req_valid && $stable(imem_addr))
    );

endmodule

// File: tb/tb_ysyx_25020047_ifu_mc.sv
// Randomized bench for the multi-cycle IFU with a transaction-level
// expectation model and a per-cycle compare process.
module tb_ysyx_25020047_ifu_mc;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] RST_PC  = 32'h8000_0000;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic        out_cause;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_dnpc;
    logic [31:0] fetch_cnt;

    ysyx_25020047_ifu_mc #(
        .RESET_PC(RST_PC),
        .TIMEOUT (TIMEOUT),
        .NOP_INST(NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .out_fault     (out_fault),
        .out_cause     (out_cause),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_dnpc       (wb_dnpc),
        .fetch_cnt     (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_mis;
    logic [31:0] cur_inst;
    bit          cur_flt;
    bit          cur_cs;

    // expectations for the current cycle
    bit          chk_en;
    bit          e_req;
    bit          e_ov;
    bit          e_wbr;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t actual=%h required=%h",
                     name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input bit rq, input bit ov, input bit wbr);
        chk_en = 1'b1;
        e_req  = rq;
        e_ov   = ov;
        e_wbr  = wbr;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_valid", 32'(imem_req_valid), 32'(e_req));
            if (e_req) check("imem_addr", imem_addr, m_pc);
            check("out_valid", 32'(out_valid), 32'(e_ov));
            if (e_ov) begin
                check("out_pc", out_pc, m_pc);
                check("out_inst", out_inst, cur_inst);
                check("out_fault", 32'(out_fault), 32'(cur_flt));
                check("out_cause", 32'(out_cause), 32'(cur_cs));
            end
            check("wb_ready", 32'(wb_ready), 32'(e_wbr));
            check("fetch_cnt", fetch_cnt, m_cnt);
        end
    end

    // k < 0: imem never answers (timeout)
    task automatic run_instr(input int stall, input int k, input bit err,
                             input logic [31:0] data, input int hold,
                             input bit same, input int nwait,
                             input logic [31:0] dnpc);
        if (!m_mis) begin
            for (int i = 0; i <= stall; i++) begin
                imem_req_ready = (i == stall);
                out_ready = 1'($urandom);
                wb_valid = 1'($urandom);
                wb_dnpc = $urandom;
                expect_cyc(1'b1, 1'b0, 1'b0);
                step();
            end
            imem_req_ready = 1'b0;
            if (k < 0) begin
                for (int j = 0; j < TIMEOUT; j++) begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data = $urandom;
                    imem_rsp_err = 1'($urandom);
                    out_ready = 1'($urandom);
                    expect_cyc(1'b0, 1'b0, 1'b0);
                    step();
                end
                cur_inst = NOP;
                cur_flt = 1'b1;
            end else begin
                for (int j = 0; j <= k; j++) begin
                    imem_rsp_valid = (j == k);
                    imem_rsp_data = (j == k) ? data : $urandom;
                    imem_rsp_err = (j == k) ? err : 1'($urandom);
                    out_ready = 1'($urandom);
                    expect_cyc(1'b0, 1'b0, 1'b0);
                    step();
                end
                cur_inst = err ? NOP : data;
                cur_flt = err;
            end
            imem_rsp_valid = 1'b0;
            imem_rsp_err = 1'b0;
            cur_cs = 1'b1;
        end else begin
            cur_inst = NOP;
            cur_flt = 1'b1;
            cur_cs = 1'b0;
        end
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            wb_valid = 1'($urandom);
            wb_dnpc = $urandom;
            expect_cyc(1'b0, 1'b1, 1'b0);
            step();
        end
        out_ready = 1'b1;
        wb_valid = same;
        wb_dnpc = same ? dnpc : $urandom;
        expect_cyc(1'b0, 1'b1, 1'b1);
        step();
        m_cnt = m_cnt + 32'd1;
        out_ready = 1'b0;
        wb_valid = 1'b0;
        if (!same) begin
            for (int i = 0; i <= nwait; i++) begin
                wb_valid = (i == nwait);
                wb_dnpc = (i == nwait) ? dnpc : $urandom;
                out_ready = 1'($urandom);
                expect_cyc(1'b0, 1'b0, 1'b1);
                step();
            end
            wb_valid = 1'b0;
            out_ready = 1'b0;
        end
        m_pc = dnpc;
        m_mis = (dnpc[1:0] != 2'b00);
        chk_en = 1'b0;
    endtask

    function automatic logic [31:0] rand_dnpc();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 5) == 0)
            return {a[31:2], 2'($urandom_range(1, 3))};
        return {a[31:2], 2'b00};
    endfunction

    initial begin
        int k;
        chk_en = 1'b0;
        e_req = 1'b0;
        e_ov = 1'b0;
        e_wbr = 1'b0;
        rst = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        imem_rsp_err = 1'b0;
        out_ready = 1'b0;
        wb_valid = 1'b0;
        wb_dnpc = '0;
        m_pc = RST_PC;
        m_cnt = '0;
        m_mis = 1'b0;
        cur_inst = NOP;
        cur_flt = 1'b0;
        cur_cs = 1'b0;
        step();
        step();
        rst = 1'b1;

        check("rst_addr", imem_addr, 32'h8000_0000);
        check("rst_req", 32'(imem_req_valid), 32'd1);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_inst", out_inst, 32'h0000_0013);
        check("rst_fault", 32'({out_fault, out_cause}), 32'd0);
        check("rst_cnt", fetch_cnt, 32'd0);

        // first fetch, 5-cycle stall, dnpc taken in the handshake cycle
        run_instr(0, 0, 1'b0, 32'h0010_0093, 5, 1'b1, 0, 32'h8000_0004);
        check("t1_inst", out_inst, 32'h0010_0093);
        check("t1_cnt", fetch_cnt, 32'd1);
        check("t3_req", 32'(imem_req_valid), 32'd1);
        check("t3_addr", imem_addr, 32'h8000_0004);

        // misaligned dnpc
        run_instr(1, 2, 1'b0, $urandom, 0, 1'b0, 1, 32'h8000_0006);
        check("t4_req", 32'(imem_req_valid), 32'd0);
        check("t4_ov", 32'(out_valid), 32'd1);
        check("t4_pc", out_pc, 32'h8000_0006);
        check("t4_inst", out_inst, 32'h0000_0013);
        check("t4_fc", 32'({out_fault, out_cause}), 32'b10);

        // timeout, response on the last legal cycle, bus error
        run_instr(0, 0, 1'b0, 32'h1, 1, 1'b0, 0, 32'h8000_0010);
        run_instr(0, -1, 1'b0, 32'h0, 0, 1'b1, 0, 32'h8000_0014);
        check("t5_fc", 32'({out_fault, out_cause}), 32'b11);
        check("t5_inst", out_inst, 32'h0000_0013);
        run_instr(2, TIMEOUT - 1, 1'b0, 32'hdead_beef, 0, 1'b1, 0,
                  32'h8000_0018);
        check("t5_late", out_inst, 32'hdead_beef);
        run_instr(0, 3, 1'b1, 32'hcafe_f00d, 2, 1'b0, 2, 32'h8000_001c);
        check("t5_err_fc", 32'({out_fault, out_cause}), 32'b11);
        check("t5_err_inst", out_inst, 32'h0000_0013);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: k = -1;
                1: k = TIMEOUT - 1;
                default: k = $urandom_range(0, 4);
            endcase
            run_instr($urandom_range(0, 2), k, ($urandom_range(0, 7) == 0),
                      $urandom, $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      rand_dnpc());
        end

        // reset while a fetch is outstanding
        while (m_mis)
            run_instr(0, 0, 1'b0, $urandom, 0, 1'b1, 0, 32'h8000_0100);
        imem_req_ready = 1'b1;
        expect_cyc(1'b1, 1'b0, 1'b0);
        step();
        imem_req_ready = 1'b0;
        expect_cyc(1'b0, 1'b0, 1'b0);
        step();
        step();
        chk_en = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        m_pc = RST_PC;
        m_cnt = '0;
        m_mis = 1'b0;
        check("t6_addr", imem_addr, 32'h8000_0000);
        check("t6_req", 32'(imem_req_valid), 32'd1);
        check("t6_ov", 32'(out_valid), 32'd0);
        check("t6_cnt", fetch_cnt, 32'd0);
        run_instr(0, 1, 1'b0, 32'h0000_0513, 1, 1'b0, 1, 32'h8000_0004);
        check("t6_cnt2", fetch_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
